// File: rtl/ddr_app_arbiter.sv
// Round-robin arbiter muxing N_REQ single-beat requesters onto one DDR4 app_* port; reads are routed back in order via a tag FIFO.
// Latency: accept at T -> app_en at T+1, one command per 2 cycles peak; no response backpressure.
module ddr_app_arbiter #(
  parameter int N_REQ          = 2,
  parameter int APP_ADDR_WIDTH = 32,
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8,
  parameter int TAG_DEPTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               init_calib_complete,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0]                   req_rd,
  input  logic [N_REQ*APP_ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ*APP_DATA_WIDTH-1:0]    req_wdata,
  input  logic [N_REQ*APP_MASK_WIDTH-1:0]    req_mask,
  output logic [N_REQ-1:0]                   rsp_valid,
  output logic [APP_DATA_WIDTH-1:0]          rsp_data,
  output logic [APP_ADDR_WIDTH-1:0]          app_addr,
  output logic [2:0]                         app_cmd,
  output logic                               app_en,
  input  logic                               app_rdy,
  output logic [APP_DATA_WIDTH-1:0]          app_wdf_data,
  output logic [APP_MASK_WIDTH-1:0]          app_wdf_mask,
  output logic                               app_wdf_wren,
  output logic                               app_wdf_end,
  input  logic                               app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]          app_rd_data,
  input  logic                               app_rd_data_valid,
  output logic                               busy,
  output logic                               err_underflow
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [IDW-1:0]            r_rr_last, r_id;
  logic                      r_rd, r_cmd_pend, r_wdat_pend;
  logic [APP_ADDR_WIDTH-1:0] r_addr;
  logic [APP_DATA_WIDTH-1:0] r_wdata, r_rsp_data;
  logic [APP_MASK_WIDTH-1:0] r_mask;
  logic [N_REQ-1:0]          r_rsp_valid;
  logic                      r_err;

  logic [IDW-1:0]            r_tag_mem [TAG_DEPTH];
  logic [PW-1:0]             r_wptr, r_rptr;
  logic [PW:0]               r_count;

  logic [N_REQ-1:0]          w_elig;
  logic                      w_found;
  logic [IDW-1:0]            w_gnt_id, w_idx;
  logic                      w_cmd_take, w_wdat_take, w_push, w_pop, w_full, w_empty;

  assign w_full      = (r_count == (PW+1)'(TAG_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_cmd_take  = r_cmd_pend && app_rdy;
  assign w_wdat_take = r_wdat_pend && app_wdf_rdy;
  assign w_push      = w_cmd_take && r_rd;
  assign w_pop       = app_rd_data_valid && !w_empty;

  // Reads stall only on a full tag FIFO; writes never do.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++)
      w_elig[i] = req_valid[i] && (!req_rd[i] || !w_full);
  end

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    if (r_state == S_IDLE && init_calib_complete && !rst) begin
      for (int k = 1; k <= N_REQ; k++) begin
        w_idx = IDW'((int'(r_rr_last) + k) % N_REQ);
        if (!w_found && w_elig[w_idx]) begin
          w_found  = 1'b1;
          w_gnt_id = w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: if ((!r_cmd_pend || app_rdy) && (!r_wdat_pend || app_wdf_rdy))
                 w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last   <= IDW'(N_REQ - 1);
      r_id        <= '0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_cmd_pend  <= 1'b0;
      r_wdat_pend <= 1'b0;
    end else if (w_found) begin
      r_rr_last   <= w_gnt_id;
      r_id        <= w_gnt_id;
      r_rd        <= req_rd[w_gnt_id];
      r_addr      <= req_addr[int'(w_gnt_id)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
      r_wdata     <= req_wdata[int'(w_gnt_id)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
      r_mask      <= req_mask[int'(w_gnt_id)*APP_MASK_WIDTH +: APP_MASK_WIDTH];
      r_cmd_pend  <= 1'b1;
      r_wdat_pend <= !req_rd[w_gnt_id];
    end else begin
      if (w_cmd_take)  r_cmd_pend  <= 1'b0;
      if (w_wdat_take) r_wdat_pend <= 1'b0;
    end
  end

  // Tag storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wptr] <= r_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rsp_valid <= w_pop ? (N_REQ'(1) << r_tag_mem[r_rptr]) : '0;
      if (w_pop) r_rsp_data <= app_rd_data;
      if (app_rd_data_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign req_ready     = w_found ? (N_REQ'(1) << w_gnt_id) : '0;
  assign app_en        = r_cmd_pend;
  assign app_wdf_wren  = r_wdat_pend;
  assign app_wdf_end   = r_wdat_pend;
  assign app_cmd       = {2'b00, r_rd};
  assign app_addr      = r_addr;
  assign app_wdf_data  = r_wdata;
  assign app_wdf_mask  = r_mask;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign busy          = (r_state == S_ISSUE) || !w_empty;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Directed bench for ddr_app_arbiter: cycle-table vectors for gating/handshake/round-robin, hand sequences for read routing, FIFO full, underflow and reset.
module tb_ddr_app_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int TD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, calib;
  logic [N-1:0]  req_valid, req_ready, req_rd, rsp_valid;
  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_wdata [N];
  logic [MW-1:0] a_mask  [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_mask;
  logic [DW-1:0] rsp_data, app_wdf_data, app_rd_data;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic [MW-1:0] app_wdf_mask;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
  logic busy, err_underflow;

  assign req_addr  = {a_addr[1], a_addr[0]};
  assign req_wdata = {a_wdata[1], a_wdata[0]};
  assign req_mask  = {a_mask[1], a_mask[0]};

  ddr_app_arbiter #(.N_REQ(N), .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW),
                    .APP_MASK_WIDTH(MW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .err_underflow(err_underflow)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  typedef struct {
    int         rep;
    logic       calib;
    logic [1:0] vld;
    logic [1:0] rd;
    logic       ardy;
    logic       wrdy;
    logic [1:0] e_rdy;
    logic       e_en;
    logic       e_wren;
    logic       e_busy;
    int         e_id;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    // calibration gate, then write with skewed data handshake
    tbl[0]  = '{20, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, -1};
    tbl[1]  = '{1,  1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, -1};
    tbl[2]  = '{1,  1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 0};
    tbl[3]  = '{2,  1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1,  1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 0};
    tbl[5]  = '{1,  1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, -1};
    // round-robin, both requesters writing, controller always ready
    tbl[6]  = '{1,  1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, -1};
    tbl[7]  = '{1,  1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1};
    tbl[8]  = '{1,  1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, -1};
    tbl[9]  = '{1,  1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 0};
    tbl[10] = '{1,  1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, -1};
    tbl[11] = '{1,  1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1};
    tbl[12] = '{1,  1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, -1};
    tbl[13] = '{1,  1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 0};
    tbl[14] = '{1,  1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, -1};

    rst = 1'b1; calib = 1'b0; req_valid = '0; req_rd = '0;
    a_addr[0] = 32'h40;  a_wdata[0] = 64'hDEADBEEF_01234567; a_mask[0] = 8'h00;
    a_addr[1] = 32'h80;  a_wdata[1] = 64'h0123_4567_89AB_CDEF; a_mask[1] = 8'hF0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;

    repeat (3) next_cyc();
    sample();
    chk("rst req_ready", 64'(req_ready), 64'h0);
    chk("rst app_en", 64'(app_en), 64'h0);
    chk("rst app_wdf_wren", 64'(app_wdf_wren), 64'h0);
    chk("rst app_cmd", 64'(app_cmd), 64'h0);
    chk("rst app_addr", 64'(app_addr), 64'h0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst err_underflow", 64'(err_underflow), 64'h0);
    next_cyc();
    rst = 1'b0;

    for (int r = 0; r < NV; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        calib = tbl[r].calib; req_valid = tbl[r].vld; req_rd = tbl[r].rd;
        app_rdy = tbl[r].ardy; app_wdf_rdy = tbl[r].wrdy;
        sample();
        chk($sformatf("v%0d.%0d req_ready", r, k), 64'(req_ready), 64'(tbl[r].e_rdy));
        chk($sformatf("v%0d.%0d app_en", r, k), 64'(app_en), 64'(tbl[r].e_en));
        chk($sformatf("v%0d.%0d app_wdf_wren", r, k), 64'(app_wdf_wren), 64'(tbl[r].e_wren));
        chk($sformatf("v%0d.%0d app_wdf_end", r, k), 64'(app_wdf_end), 64'(tbl[r].e_wren));
        chk($sformatf("v%0d.%0d busy", r, k), 64'(busy), 64'(tbl[r].e_busy));
        if (tbl[r].e_id >= 0) begin
          chk($sformatf("v%0d.%0d app_addr", r, k), 64'(app_addr), 64'(a_addr[tbl[r].e_id]));
          chk($sformatf("v%0d.%0d app_wdf_data", r, k), app_wdf_data, a_wdata[tbl[r].e_id]);
          chk($sformatf("v%0d.%0d app_wdf_mask", r, k), 64'(app_wdf_mask), 64'(a_mask[tbl[r].e_id]));
          chk($sformatf("v%0d.%0d app_cmd", r, k), 64'(app_cmd), 64'h0);
        end
        next_cyc();
      end
    end

    // read routing: req1 then req0, data returned in order
    a_addr[1] = 32'h100; a_addr[0] = 32'h200;
    req_valid = 2'b10; req_rd = 2'b10;
    sample(); chk("rd1 grant", 64'(req_ready), 64'h2);
    next_cyc(); req_valid = 2'b00;
    sample(); chk("rd1 app_en", 64'(app_en), 64'h1);
    chk("rd1 app_cmd", 64'(app_cmd), 64'h1); chk("rd1 app_addr", 64'(app_addr), 64'h100);
    next_cyc(); req_valid = 2'b01; req_rd = 2'b01;
    sample(); chk("rd0 grant", 64'(req_ready), 64'h1); chk("rd busy", 64'(busy), 64'h1);
    next_cyc(); req_valid = 2'b00;
    sample(); chk("rd0 app_addr", 64'(app_addr), 64'h200); chk("rd0 app_cmd", 64'(app_cmd), 64'h1);
    next_cyc(); app_rd_data_valid = 1'b1; app_rd_data = 64'hAAAA;
    sample(); chk("rsp not early", 64'(rsp_valid), 64'h0);
    next_cyc(); app_rd_data = 64'hBBBB;
    sample(); chk("rsp1 valid", 64'(rsp_valid), 64'h2); chk("rsp1 data", rsp_data, 64'hAAAA);
    next_cyc(); app_rd_data_valid = 1'b0;
    sample(); chk("rsp0 valid", 64'(rsp_valid), 64'h1); chk("rsp0 data", rsp_data, 64'hBBBB);
    next_cyc();
    sample(); chk("rsp idle", 64'(rsp_valid), 64'h0); chk("rd done busy", 64'(busy), 64'h0);
    next_cyc();

    // fill the tag FIFO from requester 0
    for (int i = 0; i < TD; i++) begin
      req_valid = 2'b01; req_rd = 2'b01;
      sample(); chk($sformatf("fill%0d grant", i), 64'(req_ready), 64'h1);
      next_cyc(); req_valid = 2'b00;
      sample(); chk($sformatf("fill%0d app_en", i), 64'(app_en), 64'h1);
      next_cyc();
    end
    req_valid = 2'b11; req_rd = 2'b01;
    sample(); chk("full write granted", 64'(req_ready), 64'h2);
    next_cyc(); req_valid = 2'b01;
    sample(); chk("full write cmd", 64'(app_cmd), 64'h0); chk("full write en", 64'(app_en), 64'h1);
    next_cyc();
    sample(); chk("full read blocked", 64'(req_ready), 64'h0);
    next_cyc(); app_rd_data_valid = 1'b1; app_rd_data = 64'h5555;
    sample(); chk("full read still blocked", 64'(req_ready), 64'h0);
    next_cyc(); app_rd_data_valid = 1'b0;
    sample(); chk("freed read granted", 64'(req_ready), 64'h1);
    chk("freed rsp valid", 64'(rsp_valid), 64'h1); chk("freed rsp data", rsp_data, 64'h5555);
    next_cyc(); req_valid = 2'b00;
    sample(); chk("refill app_en", 64'(app_en), 64'h1);
    next_cyc();
    for (int i = 0; i < TD; i++) begin
      app_rd_data_valid = 1'b1; app_rd_data = 64'(i + 16'h100);
      next_cyc();
      chk($sformatf("drain%0d valid", i), 64'(rsp_valid), 64'h1);
      chk($sformatf("drain%0d data", i), rsp_data, 64'(i + 16'h100));
    end
    app_rd_data_valid = 1'b0;
    sample(); chk("drained busy", 64'(busy), 64'h0); chk("drained no err", 64'(err_underflow), 64'h0);
    next_cyc();

    // underflow is sticky
    app_rd_data_valid = 1'b1; app_rd_data = 64'h7777;
    next_cyc(); app_rd_data_valid = 1'b0;
    chk("underflow set", 64'(err_underflow), 64'h1); chk("underflow no rsp", 64'(rsp_valid), 64'h0);
    next_cyc(); next_cyc();
    chk("underflow sticky", 64'(err_underflow), 64'h1);

    // reset while a write sits in ISSUE
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; req_valid = 2'b10; req_rd = 2'b00;
    sample(); chk("pre-rst grant", 64'(req_ready), 64'h2);
    next_cyc(); req_valid = 2'b00;
    sample(); chk("pre-rst app_en", 64'(app_en), 64'h1); chk("pre-rst wren", 64'(app_wdf_wren), 64'h1);
    rst = 1'b1;
    next_cyc();
    chk("post-rst app_en", 64'(app_en), 64'h0); chk("post-rst wren", 64'(app_wdf_wren), 64'h0);
    chk("post-rst err", 64'(err_underflow), 64'h0); chk("post-rst busy", 64'(busy), 64'h0);
    rst = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1; req_valid = 2'b11;
    sample(); chk("post-rst priority", 64'(req_ready), 64'h1);
    next_cyc(); req_valid = 2'b00;
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
